fir_mac_sequencer: RTL
======================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter SRL_LENGTH, default 27: number of taps N (range 2..64).
REQ-002 SHALL have parameter NUM_PRECISION, default 16: sample and coefficient width W, signed two's complement.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port data, input, W: signed input sample.
REQ-006 SHALL have port in_valid, input, 1: data is valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample.
REQ-008 SHALL have port coeff_we, input, 1: coefficient write strobe.
REQ-009 SHALL have port coeff_addr, input, 6: tap index k.
REQ-010 SHALL have port coeff_data, input, W: signed coefficient h[k].
REQ-011 SHALL have port coeff_err, output, 1: one-cycle pulse when a coefficient write is rejected.
REQ-012 SHALL have port y, output, 2W+6: signed filter output.
REQ-013 SHALL have port out_valid, output, 1: y is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts y.

Function
REQ-015 SHALL implement y[n] = sum over k=0..N-1 of h[k]*x[n-k] with one shared W x W signed multiplier and an accumulator of width 2W+6, with no saturation or rounding.
REQ-016 SHALL store samples in an N-entry circular buffer; the write pointer wraps from N-1 to 0, and tap k reads entry (wp-k) mod N.
REQ-017 SHALL use the FSM states IDLE, MAC and DONE.
REQ-018 SHALL assert in_ready only in IDLE; on in_valid&in_ready at cycle T it SHALL write the sample, clear the accumulator and enter MAC.
REQ-019 SHALL process one tap per cycle in MAC over cycles T+1..T+N, then enter DONE.
REQ-020 SHALL drive out_valid=1 from cycle T+N+1 and hold y stable until out_valid&out_ready, then return to IDLE on the next cycle.
REQ-021 SHALL ignore in_valid outside IDLE; the sample is not stored.
REQ-022 SHALL accept coefficient writes only in IDLE with coeff_addr<N.
REQ-023 SHALL ignore any other coeff_we, leave the coefficients unchanged, and pulse coeff_err for one cycle.
REQ-024 SHALL give coeff_we priority when coeff_we and in_valid&in_ready occur in the same cycle: both take effect, and the new coefficient applies to this sample's computation.

Reset
REQ-025 SHALL, while reset=0, force state IDLE, in_ready=1, out_valid=0, y=0, coeff_err=0, accumulator=0, write pointer=0, all buffer entries=0 and all coefficients=0.
REQ-026 SHALL abort any computation in progress when reset is asserted, with no out_valid produced for the aborted sample.
REQ-027 SHALL leave the block in IDLE after reset deasserts, with the next clock edge able to accept a sample.

Configuration
REQ-028 SHALL, with macro FIR_SEQ_SYMMETRIC_EN defined, require odd N and treat h as symmetric, h[N-1-k]=h[k].
REQ-029 SHALL, with FIR_SEQ_SYMMETRIC_EN defined, store only h[0..(N-1)/2]; writes to coeff_addr>(N-1)/2 are rejected per REQ-023.
REQ-030 SHALL, with FIR_SEQ_SYMMETRIC_EN defined, pre-add x[n-k]+x[n-N+1+k] at W+1 bits; the middle tap uses x alone.
REQ-031 SHALL, with FIR_SEQ_SYMMETRIC_EN defined, run MAC for (N+1)/2 cycles, so out_valid rises at T+(N+1)/2+1.
REQ-032 SHALL, without FIR_SEQ_SYMMETRIC_EN, store all N coefficients independently with an N-cycle MAC.

Verification
REQ-033 SHALL verify impulse response: set h[k]=k+1 and feed 1 then 27 zeros -> y = 1,2,...,27, then 0.
REQ-034 SHALL verify the extreme product: set all h=32767 and feed 27 samples of -32768 -> 27th y = -28990144512, with no wrap.
REQ-035 SHALL verify latency: handshake at T -> out_valid at T+28 without the macro and T+15 with it (N=27).
REQ-036 SHALL verify backpressure: hold out_ready=0 for 10 cycles -> y stable, out_valid=1, in_ready=0, and a pulsed in_valid is not stored.
REQ-037 SHALL verify write rejection: coeff_we (addr 0, data 5) during MAC -> coeff_err pulse and y computed with the old h[0]; with the macro, a write to addr 20 in IDLE -> coeff_err.
REQ-038 SHALL verify reset mid-MAC: assert reset at MAC cycle 5 -> out_valid stays 0 and all coefficients are cleared; after release, write h[0]=2 and feed 3 -> y=6.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: a single shared multiplier walks the taps of each sample.
// Define FIR_SEQ_SYMMETRIC_EN for the folded symmetric-coefficient variant (odd SRL_LENGTH only).
module fir_mac_sequencer #(
  parameter int unsigned SRL_LENGTH    = 27,
  parameter int unsigned NUM_PRECISION = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [NUM_PRECISION-1:0]   data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              coeff_we,
  input  logic        [5:0]                 coeff_addr,
  input  logic signed [NUM_PRECISION-1:0]   coeff_data,
  output logic                              coeff_err,
  output logic signed [2*NUM_PRECISION+5:0] y,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int unsigned N    = SRL_LENGTH;
  localparam int unsigned W    = NUM_PRECISION;
  localparam int unsigned AW   = 2*W + 6;
  localparam int unsigned PTRW = $clog2(N);
`ifdef FIR_SEQ_SYMMETRIC_EN
  localparam int unsigned NCOEF = (N + 1) / 2;
  localparam int unsigned XW    = W + 1;
`else
  localparam int unsigned NCOEF = N;
  localparam int unsigned XW    = W;
`endif
  localparam int unsigned PW = XW + W;
  localparam int unsigned TW = (NCOEF > 1) ? $clog2(NCOEF) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic signed [W-1:0]    xbuf [N];
  logic signed [W-1:0]    coef [NCOEF];
  logic        [PTRW-1:0] wp;
  logic        [PTRW-1:0] rp;
`ifdef FIR_SEQ_SYMMETRIC_EN
  logic        [PTRW-1:0] rp2;
  logic signed [W-1:0]    x_b;
`endif
  logic        [TW-1:0]   tap;
  logic signed [AW-1:0]   acc;

  logic                   accept_c;
  logic                   coef_wr_ok_c;
  logic                   last_tap_c;
  logic signed [W-1:0]    x_a;
  logic signed [XW-1:0]   x_op;
  logic signed [W-1:0]    h_op;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   acc_sum;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(N-1)) ? '0 : p + PTRW'(1);
  endfunction

  function automatic logic [PTRW-1:0] ptr_dec(input logic [PTRW-1:0] p);
    return (p == '0) ? PTRW'(N-1) : p - PTRW'(1);
  endfunction

  assign accept_c     = in_valid && (state == IDLE);
  assign coef_wr_ok_c = coeff_we && (state == IDLE) && ({1'b0, coeff_addr} < 7'(NCOEF));
  assign last_tap_c   = (state == MAC) && (tap == TW'(NCOEF-1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)   state_next = MAC;
      MAC:     if (last_tap_c) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Shared multiplier; symmetric build folds mirrored taps before multiplying
  always_comb begin
    x_a = xbuf[rp];
`ifdef FIR_SEQ_SYMMETRIC_EN
    x_b = xbuf[rp2];
    if (rp == rp2) x_op = {x_a[W-1], x_a};
    else           x_op = {x_a[W-1], x_a} + {x_b[W-1], x_b};
`else
    x_op = x_a;
`endif
    h_op    = coef[tap];
    prod    = PW'(x_op) * PW'(h_op);
    acc_sum = acc + {{(AW-PW){prod[PW-1]}}, prod};
  end

  // Datapath, sample buffer, coefficient store and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      coeff_err <= 1'b0;
      y         <= '0;
      acc       <= '0;
      wp        <= '0;
      rp        <= '0;
`ifdef FIR_SEQ_SYMMETRIC_EN
      rp2       <= '0;
`endif
      tap       <= '0;
      for (int i = 0; i < N; i++)     xbuf[i] <= '0;
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      coeff_err <= coeff_we && !coef_wr_ok_c;

      if (coef_wr_ok_c) coef[coeff_addr[TW-1:0]] <= coeff_data;

      if (accept_c) begin
        xbuf[wp] <= data;
        rp       <= wp;
`ifdef FIR_SEQ_SYMMETRIC_EN
        rp2      <= ptr_inc(wp);
`endif
        tap      <= '0;
        acc      <= '0;
      end

      if (state == MAC) begin
        acc <= acc_sum;
        rp  <= ptr_dec(rp);
`ifdef FIR_SEQ_SYMMETRIC_EN
        rp2 <= ptr_inc(rp2);
`endif
        tap <= tap + TW'(1);
        // Newest sample slot advances only once its output is committed
        if (last_tap_c) begin
          y  <= acc_sum;
          wp <= ptr_inc(wp);
        end
      end
    end
  end

endmodule
